// File: rtl/palette_pkg.sv
// palette_pkg: shared color types, reset palette table, flash color and flash state enum.
package palette_pkg;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  typedef enum logic {FL_IDLE, FL_FLASH} flash_state_t;
  localparam rgb_t FLASH_COLOR = '{8'hFF, 8'hFF, 8'hFF};
  localparam rgb_t DEFAULT_TABLE [8] = '{
    24'h000000, 24'h000000, 24'hB00000, 24'hC3BC1D,
    24'hFFD308, 24'h004500, 24'h37F6D4, 24'h435A63
  };
  function automatic rgb_t default_color(int i);
    return (i < 8) ? DEFAULT_TABLE[i[2:0]] : '0;
  endfunction
endpackage

// File: rtl/palette_flash_ctrl.sv
// palette_flash_ctrl: flash effect FSM, counts frame_start pulses down from FLASH_FRAMES.
module palette_flash_ctrl
  import palette_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic flash_req,
  input  logic frame_start,
  output logic flash_active
);
  flash_state_t r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic w_tick;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= FL_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  // A restart request wins over a concurrent frame tick.
  always_comb begin
    w_tick      = (r_state == FL_FLASH) && frame_start;
    w_state_nxt = flash_req ? FL_FLASH : (w_tick && r_cnt == 8'd1) ? FL_IDLE : r_state;
    w_cnt_nxt   = flash_req ? 8'(FLASH_FRAMES) : w_tick ? r_cnt - 8'd1 : r_cnt;
  end
  assign flash_active = (r_state == FL_FLASH);
endmodule

// File: rtl/color_palette_lut.sv
// color_palette_lut: banked RGB palette lookup with 1-cycle latency and write-through bypass.
// Optional flash override enabled by defining PALETTE_FLASH_EN.
module color_palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W        = 3,
  parameter int NUM_PAL      = 4,
  parameter int COLOR_W      = 8,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       pix_valid_in,
  input  logic [$clog2(NUM_PAL)-1:0] pal_sel,
  input  logic [IDX_W-1:0]           select_input,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [3*COLOR_W-1:0]       wr_rgb,
  input  logic                       frame_start,
  input  logic                       flash_req,
  output logic [COLOR_W-1:0]         Red,
  output logic [COLOR_W-1:0]         Green,
  output logic [COLOR_W-1:0]         Blue,
  output logic                       pix_valid_out,
  output logic                       flash_active
);
  localparam int DEPTH = 2**IDX_W;
  localparam int RGB_W = 3*COLOR_W;
  logic [RGB_W-1:0] r_mem [NUM_PAL][DEPTH];
  logic [RGB_W-1:0] r_rgb, w_rd;
  logic r_valid, w_flash;
  function automatic logic [RGB_W-1:0] to_rgb(rgb_t c);
    return {COLOR_W'(c.r), COLOR_W'(c.g), COLOR_W'(c.b)};
  endfunction
`ifdef PALETTE_FLASH_EN
  palette_flash_ctrl #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .flash_req(flash_req),
    .frame_start(frame_start),
    .flash_active(w_flash)
  );
`else
  logic w_unused;
  assign w_unused = flash_req ^ frame_start;
  assign w_flash  = 1'b0;
`endif
  assign w_rd = (wr_en && wr_pal == pal_sel && wr_idx == select_input) ? wr_rgb : r_mem[pal_sel][select_input];
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int i = 0; i < DEPTH; i++)
          r_mem[p][i] <= to_rgb(default_color(i));
    end else if (wr_en) begin
      r_mem[wr_pal][wr_idx] <= wr_rgb;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rgb   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_rgb   <= !pix_valid_in ? '0 : w_flash ? to_rgb(FLASH_COLOR) : w_rd;
      r_valid <= pix_valid_in;
    end
  end
  assign Red           = r_rgb[RGB_W-1 -: COLOR_W];
  assign Green         = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign Blue          = r_rgb[COLOR_W-1:0];
  assign pix_valid_out = r_valid;
  assign flash_active  = w_flash;
endmodule

// File: tb/tb_color_palette_lut.sv
// tb_color_palette_lut: directed self-checking bench; flash scenarios track PALETTE_FLASH_EN.
module tb_color_palette_lut;
  logic Clk = 0, Reset_n = 0;
  logic pix_valid_in = 0, wr_en = 0, frame_start = 0, flash_req = 0;
  logic [1:0] pal_sel = 0, wr_pal = 0;
  logic [2:0] select_input = 0, wr_idx = 0;
  logic [23:0] wr_rgb = 0;
  logic [7:0] Red, Green, Blue;
  logic pix_valid_out, flash_active;
  logic [23:0] w_rgb;
  int checks = 0, passed = 0;
  logic [23:0] dflt [8] = '{24'h000000, 24'h000000, 24'hB00000, 24'hC3BC1D,
                           24'hFFD308, 24'h004500, 24'h37F6D4, 24'h435A63};

  color_palette_lut dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid_in(pix_valid_in), .pal_sel(pal_sel),
    .select_input(select_input), .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx),
    .wr_rgb(wr_rgb), .frame_start(frame_start), .flash_req(flash_req),
    .Red(Red), .Green(Green), .Blue(Blue), .pix_valid_out(pix_valid_out),
    .flash_active(flash_active)
  );
  assign w_rgb = {Red, Green, Blue};
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic lookup(input logic [1:0] p, input logic [2:0] i);
    pix_valid_in = 1; pal_sel = p; select_input = i;
    step();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (w_rgb !== 24'h0) $display("FAIL reset_rgb got %h want 000000", w_rgb); else passed++;
    checks++; if (pix_valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", pix_valid_out); else passed++;
    checks++; if (flash_active !== 1'b0) $display("FAIL reset_flash got %b want 0", flash_active); else passed++;
    Reset_n = 1;
    step();
  endtask

  task automatic test_lookup();
    lookup(0, 3);
    checks++; if (w_rgb !== 24'hC3BC1D) $display("FAIL lookup_b0i3 got %h want C3BC1D", w_rgb); else passed++;
    checks++; if (pix_valid_out !== 1'b1) $display("FAIL lookup_valid got %b want 1", pix_valid_out); else passed++;
    for (int i = 0; i < 8; i++) begin
      lookup(1, 3'(i));
      checks++; if (w_rgb !== dflt[i]) $display("FAIL default_b1i%0d got %h want %h", i, w_rgb, dflt[i]); else passed++;
    end
    pix_valid_in = 0; pal_sel = 0; select_input = 4;
    step();
    checks++; if (w_rgb !== 24'h0 || pix_valid_out !== 1'b0)
      $display("FAIL blank got %h/%b want 000000/0", w_rgb, pix_valid_out); else passed++;
  endtask

  task automatic test_write();
    wr_en = 1; wr_pal = 2; wr_idx = 5; wr_rgb = 24'h123456; pix_valid_in = 0;
    step();
    wr_en = 0;
    lookup(2, 5);
    checks++; if (w_rgb !== 24'h123456) $display("FAIL write_b2i5 got %h want 123456", w_rgb); else passed++;
    lookup(0, 5);
    checks++; if (w_rgb !== 24'h004500) $display("FAIL other_bank_b0i5 got %h want 004500", w_rgb); else passed++;
    pix_valid_in = 0; wr_en = 1; wr_pal = 3; wr_idx = 0; wr_rgb = 24'h0A0B0C;
    step();
    wr_en = 0;
    lookup(3, 0);
    checks++; if (w_rgb !== 24'h0A0B0C) $display("FAIL write_idx0 got %h want 0A0B0C", w_rgb); else passed++;
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_pal = 1; wr_idx = 4; wr_rgb = 24'hABCDEF;
    lookup(1, 4);
    wr_en = 0;
    checks++; if (w_rgb !== 24'hABCDEF) $display("FAIL bypass got %h want ABCDEF", w_rgb); else passed++;
    wr_en = 1; wr_pal = 0; wr_idx = 4; wr_rgb = 24'h777777;
    lookup(1, 4);
    wr_en = 0;
    checks++; if (w_rgb !== 24'hABCDEF) $display("FAIL no_bypass_other_bank got %h want ABCDEF", w_rgb); else passed++;
  endtask

  task automatic test_back_to_back();
    lookup(0, 6);
    checks++; if (w_rgb !== 24'h37F6D4) $display("FAIL b2b_0 got %h want 37F6D4", w_rgb); else passed++;
    lookup(2, 5);
    checks++; if (w_rgb !== 24'h123456) $display("FAIL b2b_1 got %h want 123456", w_rgb); else passed++;
    lookup(0, 4);
    checks++; if (w_rgb !== 24'h777777) $display("FAIL b2b_2 got %h want 777777", w_rgb); else passed++;
    lookup(3, 7);
    checks++; if (w_rgb !== 24'h435A63) $display("FAIL b2b_3 got %h want 435A63", w_rgb); else passed++;
  endtask

`ifdef PALETTE_FLASH_EN
  task automatic test_flash();
    flash_req = 1; pix_valid_in = 0;
    step();
    flash_req = 0;
    checks++; if (flash_active !== 1'b1) $display("FAIL flash_start got %b want 1", flash_active); else passed++;
    for (int k = 1; k <= 8; k++) begin
      frame_start = 1;
      lookup(0, 3);
      checks++; if (w_rgb !== 24'hFFFFFF) $display("FAIL flash_pix%0d got %h want FFFFFF", k, w_rgb); else passed++;
      checks++; if (flash_active !== (k < 8)) $display("FAIL flash_act%0d got %b want %b", k, flash_active, k < 8); else passed++;
    end
    frame_start = 0;
    lookup(0, 3);
    checks++; if (w_rgb !== 24'hC3BC1D) $display("FAIL post_flash got %h want C3BC1D", w_rgb); else passed++;
    flash_req = 1; pix_valid_in = 0;
    step();
    flash_req = 0;
    step();
    checks++; if (w_rgb !== 24'h0 || pix_valid_out !== 1'b0)
      $display("FAIL flash_blank got %h/%b want 000000/0", w_rgb, pix_valid_out); else passed++;
    frame_start = 1;
    for (int k = 0; k < 8; k++) step();
    frame_start = 0;
    checks++; if (flash_active !== 1'b0) $display("FAIL flash_end got %b want 0", flash_active); else passed++;
  endtask

  task automatic test_restart();
    flash_req = 1; pix_valid_in = 0;
    step();
    flash_req = 0; frame_start = 1;
    step();
    step();
    flash_req = 1;
    step();
    flash_req = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (flash_active !== (k < 8)) $display("FAIL restart_act%0d got %b want %b", k, flash_active, k < 8); else passed++;
    end
    frame_start = 0;
  endtask
`else
  task automatic test_flash();
    flash_req = 1; frame_start = 1;
    lookup(0, 3);
    flash_req = 0;
    checks++; if (flash_active !== 1'b0) $display("FAIL flash_disabled got %b want 0", flash_active); else passed++;
    lookup(0, 3);
    frame_start = 0;
    checks++; if (w_rgb !== 24'hC3BC1D) $display("FAIL flash_disabled_pix got %h want C3BC1D", w_rgb); else passed++;
  endtask

  task automatic test_restart();
    flash_req = 1;
    step();
    flash_req = 0;
    step();
    checks++; if (flash_active !== 1'b0) $display("FAIL restart_disabled got %b want 0", flash_active); else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    wr_en = 1; wr_pal = 3; wr_idx = 2; wr_rgb = 24'h111111; pix_valid_in = 0;
    step();
    wr_en = 0; flash_req = 1;
    lookup(3, 2);
    flash_req = 0;
    wr_en = 1; wr_pal = 2; wr_idx = 5; wr_rgb = 24'h999999;
    #2 Reset_n = 0;
    #1;
    wr_en = 0;
    checks++; if (w_rgb !== 24'h0 || pix_valid_out !== 1'b0)
      $display("FAIL async_reset got %h/%b want 000000/0", w_rgb, pix_valid_out); else passed++;
    checks++; if (flash_active !== 1'b0) $display("FAIL async_reset_flash got %b want 0", flash_active); else passed++;
    #2 Reset_n = 1;
    lookup(3, 2);
    checks++; if (w_rgb !== 24'hB00000) $display("FAIL reset_restore_b3i2 got %h want B00000", w_rgb); else passed++;
    lookup(2, 5);
    checks++; if (w_rgb !== 24'h004500) $display("FAIL reset_restore_b2i5 got %h want 004500", w_rgb); else passed++;
    lookup(1, 4);
    checks++; if (w_rgb !== 24'hFFD308) $display("FAIL reset_restore_b1i4 got %h want FFD308", w_rgb); else passed++;
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_write();
    test_bypass();
    test_back_to_back();
    test_flash();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/color_palette_lut.md
COLOR_PALETTE_LUT -- requirements
Module: color_palette_lut

Interface
REQ-001 SHALL have parameter IDX_W, default 3, palette index width (entries per palette = 2**IDX_W).
REQ-002 SHALL have parameter NUM_PAL, default 4, number of palette banks (>=2, power of two).
REQ-003 SHALL have parameter COLOR_W, default 8, width of each color component.
REQ-004 SHALL have parameter FLASH_FRAMES, default 8, frame count of one flash effect (1..255).
REQ-005 Clk  input  1  single clock; all state on rising edge.
REQ-006 Reset_n  input  1  reset, asynchronous and active-low.
REQ-007 pix_valid_in  input  1  pixel lookup request this cycle.
REQ-008 pal_sel  input  $clog2(NUM_PAL)  palette bank for the lookup.
REQ-009 select_input  input  IDX_W  palette index for the lookup.
REQ-010 wr_en  input  1  palette entry write strobe.
REQ-011 wr_pal  input  $clog2(NUM_PAL)  bank to write.
REQ-012 wr_idx  input  IDX_W  entry to write.
REQ-013 wr_rgb  input  3*COLOR_W  write data, {R,G,B}, R in MSBs.
REQ-014 frame_start  input  1  one-cycle pulse per video frame.
REQ-015 flash_req  input  1  one-cycle flash trigger.
REQ-016 Red, Green, Blue  output  COLOR_W each  registered looked-up color.
REQ-017 pix_valid_out  output  1  Red/Green/Blue valid this cycle.
REQ-018 flash_active  output  1  flash effect in progress.

Function
REQ-019 Lookup latency SHALL be exactly 1 cycle: pix_valid_out(n+1)=pix_valid_in(n); RGB(n+1)=entry[pal_sel(n)][select_input(n)].
REQ-020 When pix_valid_in=0, next cycle SHALL drive pix_valid_out=0 and Red=Green=Blue=0 (blanking).
REQ-021 wr_en=1 SHALL update entry[wr_pal][wr_idx] at the clock edge; write has priority over nothing else, reads and writes proceed in the same cycle.
REQ-022 Read and write to the same entry in the same cycle SHALL return the new wr_rgb (write-through bypass).
REQ-023 Index 0 of every bank SHALL be writable; no entry is special-cased in hardware.
REQ-024 Flash FSM states IDLE, FLASH; IDLE->FLASH on flash_req, loading frame counter with FLASH_FRAMES.
REQ-025 In FLASH, frame_start SHALL decrement the counter; counter reaching 0 SHALL return to IDLE on that same edge.
REQ-026 flash_req in FLASH SHALL reload the counter to FLASH_FRAMES (restart); flash_req and frame_start together SHALL reload, not decrement.
REQ-027 flash_active SHALL be 1 exactly while in FLASH (registered).
REQ-028 In FLASH, valid output pixels SHALL be FLASH_COLOR (all components all-ones) regardless of palette contents; blanked pixels stay 0.

Reset
REQ-029 Reset_n low SHALL asynchronously force Red=Green=Blue=0, pix_valid_out=0, flash_active=0, FSM=IDLE, counter=0.
REQ-030 Reset SHALL load every bank with the package default table: idx0 000000, idx1 000000, idx2 B00000, idx3 C3BC1D, idx4 FFD308, idx5 004500, idx6 37F6D4, idx7 435A63; indices >=8 load 000000.
REQ-031 Reset mid-flash or mid-write SHALL abort; no partial write persists beyond the reset table.

Configuration
REQ-032 With PALETTE_FLASH_EN defined, REQ-024..REQ-028 SHALL apply.
REQ-033 Without PALETTE_FLASH_EN, flash FSM and counter SHALL be absent, flash_req/frame_start ignored, flash_active tied 0; ports remain.

Structure
REQ-034 Package palette_pkg SHALL hold the default color table, rgb_t struct typedef, FLASH_COLOR constant and flash state enum.
REQ-035 Flash FSM plus counter SHALL be sub-module palette_flash_ctrl (inputs Clk, Reset_n, flash_req, frame_start; output flash_active).

Verification
REQ-036 Reset, lookup bank 0 idx 3 -> one cycle later RGB=C3,BC,1D, pix_valid_out=1.
REQ-037 Write bank 2 idx 5 = 123456, lookup bank 2 idx 5 next cycle -> 12,34,56; bank 0 idx 5 still 00,45,00.
REQ-038 Same-cycle write bank 1 idx 4 = ABCDEF and lookup bank 1 idx 4 -> output AB,CD,EF.
REQ-039 flash_req, then 8 frame_start pulses with valid pixels -> FF,FF,FF and flash_active=1 until 8th pulse; palette colors after.
REQ-040 flash_req at 3rd frame_start of a flash -> 8 further frame_starts required before flash_active=0.
REQ-041 Assert Reset_n low during flash after writing bank 3 -> outputs 0 immediately; bank 3 idx 2 reads B00000 after release.
